dac_sample_feeder: RTL and testbench
====================================

// Module: dac_sample_feeder
//
// PURPOSE
//   Sample-rate to DAC-rate bridge feeding the PDM DAC input (din).
//   - Accepts signed two's-complement audio samples through a valid/ready handshake and buffers them in a small FIFO.
//   - Pops one sample per sample period and linearly interpolates from the previous sample to the new one, one step per clk.
//   - Converts the result to offset binary, which is the unsigned code the PDM DAC expects.
//
// PARAMETERS
//   DATA_BITS        12  sample and DAC code width; must match the DAC's DATA_BITS
//   FIFO_DEPTH_LOG2   2  FIFO holds 2**FIFO_DEPTH_LOG2 samples
//   SAMPLE_DIV_LOG2  10  sample period = 2**SAMPLE_DIV_LOG2 clk cycles; also the interpolation length
//
// PORTS
//   clk           in   1                    system clock; all logic on posedge
//   rst           in   1                    asynchronous, active-high reset
//   sample_in     in   DATA_BITS            signed sample, two's complement
//   sample_valid  in   1                    sample_in is valid this cycle
//   sample_ready  out  1                    FIFO can accept; transfer = valid & ready
//   dac_out       out  DATA_BITS            offset-binary code; connects to DAC din
//   sample_tick   out  1                    1-cycle pulse at each sample-period boundary
//   underrun      out  1                    1-cycle pulse: tick occurred with FIFO empty
//   fifo_level    out  FIFO_DEPTH_LOG2+1    number of samples currently buffered
//
// BEHAVIOUR
//   Reset values (asynchronous, take effect immediately)
//   - FIFO empty; fifo_level = 0; sample_ready = 1.
//   - Divider = 0; prev = target = 0; acc = 0.
//   - dac_out = 2**(DATA_BITS-1) (midscale, 0x800 at 12 bits); sample_tick = 0; underrun = 0.
//
//   FIFO
//   - sample_ready = (fifo_level != 2**FIFO_DEPTH_LOG2), driven from registered state.
//   - Transfer occurs when sample_valid & sample_ready; data is written at that posedge.
//   - Push and pop in the same cycle: both occur and fifo_level is unchanged.
//   - While full, sample_ready = 0, even if a pop occurs in that same cycle.
//   - Pointers wrap modulo depth. Order is strictly first-in, first-out.
//
//   Divider
//   - Free-running counter of SAMPLE_DIV_LOG2 bits.
//   - Tick = counter at all-ones; sample_tick is registered, asserted the cycle after the tick.
//
//   On tick, FIFO not empty
//   - prev <= target; target <= FIFO head (popped).
//   - acc <= target << SAMPLE_DIV_LOG2 (the old target).
//
//   On tick, FIFO empty
//   - underrun pulses; no pop.
//   - prev <= target; target unchanged, so the output holds flat at the last value.
//
//   Every non-tick cycle
//   - acc <= acc + delta, with delta = target - prev.
//   - delta is signed, DATA_BITS+1 bits; acc is signed, DATA_BITS+SAMPLE_DIV_LOG2+1 bits, so no overflow is possible.
//   - Interpolation is exact: acc equals target << SAMPLE_DIV_LOG2 after 2**SAMPLE_DIV_LOG2 - 1 increments plus the reload.
//
//   Output
//   - dac_out <= (acc >>> SAMPLE_DIV_LOG2)[DATA_BITS-1:0] with MSB inverted (signed to offset binary). Registered, 1 clk after acc.
//
//   Latency
//   - A sample accepted into an empty FIFO is popped at the next tick.
//   - dac_out reaches that sample's value exactly one sample period (2**SAMPLE_DIV_LOG2 clks) after the pop, plus 1 clk.
//   - The output is monotonic between endpoints. Endpoint extremes (-2**(DATA_BITS-1), 2**(DATA_BITS-1)-1) are reached with no wrap.
//
//   Reset mid-operation
//   - All state returns to the reset values above. Buffered samples are discarded and dac_out snaps to midscale.
//
// TESTING
//   (SAMPLE_DIV_LOG2 = 4 for speed unless stated)
//   1. Reset, no input
//      -> dac_out = 0x800 constantly; underrun pulses every 16 clks; sample_tick every 16 clks.
//   2. Push 0x7FF from midscale
//      -> dac_out ramps 0x800 -> 0xFFF over 16 clks after the pop, monotonic, final value exact, then holds.
//   3. Push 0x800 (most negative) after 0x7FF
//      -> ramp down to 0x000 exactly, no wrap; then underrun while holding 0x000.
//   4. Push 5 samples back-to-back with depth 4
//      -> sample_ready drops after the 4th; 5th is accepted only after the next pop; popped order is 1,2,3,4,5.
//   5. Push on the exact tick cycle with the FIFO full-1
//      -> push and pop are simultaneous; fifo_level is unchanged; no sample is lost.
//   6. Assert rst mid-ramp with 3 samples buffered
//      -> dac_out = 0x800 immediately; fifo_level = 0; the buffered samples never appear after rst is released.

Source files
------------

// File: rtl/dac_sample_feeder_if.sv
// Sample stream into the DAC feeder: signed samples moved by a valid/ready handshake.
// A transfer happens on a clk posedge where sample_valid and sample_ready are both high.
interface dac_sample_feeder_if #(
  parameter int DATA_BITS = 12
);
  logic [DATA_BITS-1:0] sample_in;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/dac_sample_feeder.sv
// Sample-rate to DAC-rate bridge for a PDM DAC.
// Signed samples are buffered in a small FIFO. One sample is popped per sample period.
// The output moves linearly from the previous sample to the new one, one step per clk.
// The result is converted to offset binary for the DAC din input.
module dac_sample_feeder #(
  parameter int DATA_BITS       = 12,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SAMPLE_DIV_LOG2 = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  dac_sample_feeder_if.slave         s,
  output logic [DATA_BITS-1:0]       dac_out,
  output logic                       sample_tick,
  output logic                       underrun,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;
  localparam int ACC_BITS = DATA_BITS + SAMPLE_DIV_LOG2 + 1;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DATA_BITS-1:0]     MIDSCALE   = {1'b1, {(DATA_BITS-1){1'b0}}};

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0]       mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   level_reg;

  // Sample-period divider and output pulses
  logic [SAMPLE_DIV_LOG2-1:0] div_reg;
  logic                       tick_reg;
  logic                       underrun_reg;

  // Interpolator: prev -> target ramp held in a fixed-point accumulator
  logic signed [DATA_BITS-1:0] prev_reg;
  logic signed [DATA_BITS-1:0] target_reg;
  logic signed [ACC_BITS-1:0]  acc_reg;
  logic [DATA_BITS-1:0]        dac_reg;

  logic                        ready;
  logic                        empty;
  logic                        tick;
  logic                        push;
  logic                        pop;
  logic signed [DATA_BITS:0]   delta;
  logic                        unused_acc_bits;

  assign ready = (level_reg != FULL_LEVEL);
  assign empty = (level_reg == '0);
  assign tick  = &div_reg;
  assign push  = s.sample_valid & ready;
  assign pop   = tick & ~empty;

  // Sign-extend both endpoints by one bit so the slope never overflows.
  assign delta = {target_reg[DATA_BITS-1], target_reg} - {prev_reg[DATA_BITS-1], prev_reg};

  // The shift drops the fractional bits, and the top guard bit is always a copy of the sign.
  assign unused_acc_bits = ^{acc_reg[ACC_BITS-1], acc_reg[SAMPLE_DIV_LOG2-1:0]};

  assign s.sample_ready = ready;
  assign fifo_level     = level_reg;
  assign sample_tick    = tick_reg;
  assign underrun       = underrun_reg;
  assign dac_out        = dac_reg;

  // FIFO data write; the storage itself needs no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s.sample_in;
    end
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        level_reg <= level_reg + 1'b1;
      end else if (pop && !push) begin
        level_reg <= level_reg - 1'b1;
      end
    end
  end

  // Free-running divider with registered tick and underrun pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg      <= '0;
      tick_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      div_reg      <= div_reg + 1'b1;
      tick_reg     <= tick;
      underrun_reg <= tick & empty;
    end
  end

  // Endpoint update on tick, otherwise one slope step per clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg   <= '0;
      target_reg <= '0;
      acc_reg    <= '0;
    end else if (tick) begin
      prev_reg <= target_reg;
      if (!empty) begin
        target_reg <= mem[rd_ptr_reg];
      end
      // Reload to the exact old target so rounding error never accumulates.
      acc_reg <= {target_reg[DATA_BITS-1], target_reg, {SAMPLE_DIV_LOG2{1'b0}}};
    end else begin
      acc_reg <= acc_reg + {{SAMPLE_DIV_LOG2{delta[DATA_BITS]}}, delta};
    end
  end

  // Integer part of the accumulator with the sign bit flipped to give offset binary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac_reg <= MIDSCALE;
    end else begin
      dac_reg <= {~acc_reg[SAMPLE_DIV_LOG2+DATA_BITS-1],
                  acc_reg[SAMPLE_DIV_LOG2+DATA_BITS-2:SAMPLE_DIV_LOG2]};
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Self-checking bench for dac_sample_feeder with a short sample period of 16 clks.
// A behavioural model tracks the FIFO as a queue and the output as a closed-form
// linear interpolation between segment endpoints. Directed scenarios are followed
// by a randomized run.
`timescale 1ns/1ps
module tb_dac_sample_feeder;

  localparam int DB    = 12;
  localparam int FL    = 2;
  localparam int SL    = 4;
  localparam int DEPTH = 4;
  localparam int PER   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] dac_out;
  logic        sample_tick;
  logic        underrun;
  logic [2:0]  fifo_level;

  dac_sample_feeder_if #(.DATA_BITS(DB)) sif ();

  dac_sample_feeder #(
    .DATA_BITS(DB),
    .FIFO_DEPTH_LOG2(FL),
    .SAMPLE_DIV_LOG2(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(sif),
    .dac_out(dac_out),
    .sample_tick(sample_tick),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int q[$];
  int popped[$];
  int mdl_n     = 0;
  int seg_start = 0;
  int seg_end   = 0;
  int seg_k     = 0;
  int exp_dac   = 'h800;
  int exp_tick  = 0;
  int exp_under = 0;

  // Value on the straight line from seg_start to seg_end, seg_k steps of PER, rounded down.
  function automatic int lerp_val();
    return (seg_start * PER + seg_k * (seg_end - seg_start)) >>> SL;
  endfunction

  function automatic int to_code(int v);
    return (v & 'hFFF) ^ 'h800;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        mdl_n     = 0;
        seg_start = 0;
        seg_end   = 0;
        seg_k     = 0;
        exp_dac   = 'h800;
        exp_tick  = 0;
        exp_under = 0;
      end else begin
        int  pre;
        int  head;
        bit  tk;
        bit  do_push;
        exp_dac   = to_code(lerp_val());
        pre       = q.size();
        tk        = (mdl_n == PER - 1);
        do_push   = sif.sample_valid && (pre != DEPTH);
        exp_tick  = tk ? 1 : 0;
        exp_under = (tk && pre == 0) ? 1 : 0;
        if (tk) begin
          seg_start = seg_end;
          if (pre > 0) begin
            head = q.pop_front();
            popped.push_back(head);
            seg_end = head;
          end
          seg_k = 0;
        end else begin
          seg_k++;
        end
        if (do_push) q.push_back(int'($signed(sif.sample_in)));
        mdl_n = (mdl_n + 1) % PER;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit chk_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("dac_out",      int'(dac_out),          exp_dac);
        check("sample_tick",  int'(sample_tick),      exp_tick);
        check("underrun",     int'(underrun),         exp_under);
        check("fifo_level",   int'(fifo_level),       q.size());
        check("sample_ready", int'(sif.sample_ready), (q.size() != DEPTH) ? 1 : 0);
      end
    end
  end

  // ---------------- driver helpers (all activity at negedge) ----------------
  int stall_cycles = 0;

  task automatic push(input logic [11:0] v);
    int waited = 0;
    sif.sample_in    = v;
    sif.sample_valid = 1'b1;
    while (!sif.sample_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    stall_cycles += waited;
    check("push_accepted", int'(sif.sample_ready), 1);
    @(negedge clk);
  endtask

  task automatic idle();
    sif.sample_valid = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    int guard = 0;
    while (mdl_n != target && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("phase_reached", mdl_n, target);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int bad;
    int last;
    int base;
    sif.sample_in    = '0;
    sif.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 1: idle after reset -> midscale, two underruns per 32 clks
    cnt = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (underrun) cnt++;
      if (dac_out != 12'h800) bad++;
    end
    check("idle_underruns", cnt, 2);
    check("idle_not_mid", bad, 0);

    // 2: full-scale positive ramp, non-decreasing
    push(12'h7FF);
    idle();
    last = int'(dac_out); bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(dac_out) < last) bad++;
      last = int'(dac_out);
    end
    check("ramp_up_monotonic", bad, 0);
    check("ramp_up_final", int'(dac_out), 'hFFF);

    // 3: most negative sample, non-increasing ramp to 0x000, then underrun while holding
    push(12'h800);
    idle();
    last = int'(dac_out); bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'(dac_out) > last) bad++;
      last = int'(dac_out);
    end
    check("ramp_down_monotonic", bad, 0);
    check("ramp_down_final", int'(dac_out), 'h000);
    cnt = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (underrun) cnt++;
      if (dac_out != 12'h000) bad++;
    end
    check("hold_underruns", cnt, 2);
    check("hold_at_zero", bad, 0);

    // 4: five back-to-back pushes into depth 4
    wait_phase(0);
    base = popped.size();
    stall_cycles = 0;
    for (int i = 1; i <= 5; i++) push(12'(i));
    idle();
    check("fifth_stalled", (stall_cycles > 0) ? 1 : 0, 1);
    repeat (120) @(negedge clk);
    check("order_count", popped.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < popped.size()) check("order", popped[base + i], i + 1);
    end

    // 5: push on the tick cycle with three buffered -> push and pop together
    wait_phase(0);
    base = popped.size();
    push(12'h111);
    push(12'h222);
    push(12'h333);
    idle();
    wait_phase(15);
    push(12'h444);
    idle();
    check("level_after_pushpop", int'(fifo_level), 3);
    repeat (100) @(negedge clk);
    check("pushpop_count", popped.size() - base, 4);
    if (base + 3 < popped.size()) check("pushpop_last", popped[base + 3], 'h444);

    // 6: asynchronous reset mid-ramp with three samples buffered
    wait_phase(0);
    push(12'h100);
    push(12'h200);
    push(12'h300);
    push(12'h400);
    idle();
    wait_phase(3);
    check("pre_reset_level", int'(fifo_level), 3);
    #2 rst = 1'b1;
    #1;
    check("reset_dac_now", int'(dac_out), 'h800);
    check("reset_level_now", int'(fifo_level), 0);
    check("reset_ready_now", int'(sif.sample_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (dac_out != 12'h800) bad++;
    end
    check("no_stale_samples", bad, 0);

    // 7: randomized traffic, including full-scale extremes
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) < 2) begin
        case ($urandom_range(0, 3))
          0:       sif.sample_in = 12'h7FF;
          1:       sif.sample_in = 12'h800;
          default: sif.sample_in = 12'($urandom);
        endcase
        sif.sample_valid = 1'b1;
      end else begin
        sif.sample_valid = 1'b0;
      end
    end
    idle();
    repeat (100) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
